// File: rtl/full_adder_unit_pkg.sv
// Shared constants for the full adder datapath cell: bit positions of the
// operands and results within one lane, and the per-lane field widths.
package fa_pkg;

  // Operand positions inside a 3-bit lane slice of `in`.
  localparam int FA_A = 0;
  localparam int FA_B = 1;
  localparam int FA_C = 2;

  // Result positions inside a 2-bit lane slice of `out`.
  localparam int FA_SUM   = 0;
  localparam int FA_CARRY = 1;

  localparam int FA_IN_W  = 3;
  localparam int FA_OUT_W = 2;

endpackage

// File: rtl/full_adder_unit_if.sv
// Operand/result bundle for full_adder_unit. The master drives operands and
// observes results; the slave (the adder) consumes operands and drives results.
// There is no valid/ready: a result exists for every clock (or instantly when
// unregistered), so neither side can stall the other.
interface full_adder_unit_if #(
  parameter int NUM_LANES = 1
);

  logic [fa_pkg::FA_IN_W*NUM_LANES-1:0]  in;
  logic [fa_pkg::FA_OUT_W*NUM_LANES-1:0] out;

  modport master (
    output in,
    input  out
  );

  modport slave (
    input  in,
    output out
  );

endinterface

// File: rtl/full_adder_bit.sv
// Single combinational full adder cell: three equal-weight bits in,
// {carry, sum} out. Any input may serve as the carry-in.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/full_adder_unit.sv
// NUM_LANES independent full adders with an optional output register.
// Lanes never share carries; each lane is a standalone ripple/array cell.
module full_adder_unit
  import fa_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter bit REG_OUT   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  full_adder_unit_if.slave         bus
);

  localparam int IN_W  = FA_IN_W  * NUM_LANES;
  localparam int OUT_W = FA_OUT_W * NUM_LANES;

  logic [OUT_W-1:0] result_comb;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    full_adder_bit u_bit (
      .a     (bus.in[FA_IN_W*k + FA_A]),
      .b     (bus.in[FA_IN_W*k + FA_B]),
      .c     (bus.in[FA_IN_W*k + FA_C]),
      .sum   (result_comb[FA_OUT_W*k + FA_SUM]),
      .carry (result_comb[FA_OUT_W*k + FA_CARRY])
    );
  end

  if (REG_OUT) begin : g_reg
    logic [OUT_W-1:0] out_q;

    // No power-on value: the register is undefined until the first reset edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        out_q <= '0;
      end else begin
        out_q <= result_comb;
      end
    end

    assign bus.out = out_q;
  end else begin : g_comb
    assign bus.out = result_comb;
  end

  // Elaboration-time guard: the interface must be sized for the same lane count.
  if ($bits(bus.in) != IN_W) begin : g_width_check
    $error("full_adder_unit: interface in width does not match NUM_LANES");
  end

endmodule

// File: tb/tb_full_adder_unit.sv
// Directed bench for full_adder_unit: one-lane registered, one-lane
// combinational and two-lane registered instances.
`timescale 1ns/1ps
module tb_full_adder_unit;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clk_comb = 1'b0;  // held low: the combinational instance sees no clock
  logic rst_comb = 1'b0;

  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: sim time=%0t required=<20000", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- DUTs ----------------
  full_adder_unit_if #(.NUM_LANES(1)) reg_if ();
  full_adder_unit_if #(.NUM_LANES(1)) comb_if ();
  full_adder_unit_if #(.NUM_LANES(2)) two_if ();

  full_adder_unit #(.NUM_LANES(1), .REG_OUT(1'b1)) u_reg (
    .clk (clk),
    .rst (rst),
    .bus (reg_if)
  );

  full_adder_unit #(.NUM_LANES(1), .REG_OUT(1'b0)) u_comb (
    .clk (clk_comb),
    .rst (rst_comb),
    .bus (comb_if)
  );

  full_adder_unit #(.NUM_LANES(2), .REG_OUT(1'b1)) u_two (
    .clk (clk),
    .rst (rst),
    .bus (two_if)
  );

  // ---------------- driver helpers ----------------
  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    reg_if.in = 3'b111;
    two_if.in = 6'b111_111;
    for (int i = 0; i < 2; i++) begin
      edge_sample();
      checks++;
      if (reg_if.out !== 2'b00) begin
        errors++;
        $display("FAIL reset_hold[%0d]: out=%b expected=00", i, reg_if.out);
      end
      checks++;
      if (two_if.out !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold_two[%0d]: out=%b expected=0000", i, two_if.out);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    edge_sample();
    checks++;
    if (reg_if.out !== 2'b11) begin
      errors++;
      $display("FAIL reset_release: out=%b expected=11", reg_if.out);
    end
  endtask

  task automatic test_sweep();
    logic [2:0] vec [8];
    logic [1:0] exp [8];
    vec = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011, 3'b101, 3'b110, 3'b111};
    exp = '{2'b00,  2'b01,  2'b01,  2'b01,  2'b10,  2'b10,  2'b10,  2'b11};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      reg_if.in = vec[i];
      edge_sample();
      checks++;
      if (reg_if.out !== exp[i]) begin
        errors++;
        $display("FAIL sweep in=%b: out=%b expected=%b", vec[i], reg_if.out, exp[i]);
      end
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    reg_if.in = 3'b000;
    edge_sample();
    checks++;
    if (reg_if.out !== 2'b00) begin
      errors++;
      $display("FAIL latency_base: out=%b expected=00", reg_if.out);
    end
    #1;
    reg_if.in = 3'b111;
    #1;
    checks++;
    if (reg_if.out !== 2'b00) begin
      errors++;
      $display("FAIL latency_hold: out=%b expected=00", reg_if.out);
    end
    edge_sample();
    checks++;
    if (reg_if.out !== 2'b11) begin
      errors++;
      $display("FAIL latency_update: out=%b expected=11", reg_if.out);
    end
  endtask

  task automatic test_midstream_reset();
    @(negedge clk);
    reg_if.in = 3'b110;
    edge_sample();
    checks++;
    if (reg_if.out !== 2'b10) begin
      errors++;
      $display("FAIL midrst_pre: out=%b expected=10", reg_if.out);
    end
    @(negedge clk);
    rst = 1'b1;
    edge_sample();
    checks++;
    if (reg_if.out !== 2'b00) begin
      errors++;
      $display("FAIL midrst_clear: out=%b expected=00", reg_if.out);
    end
    @(negedge clk);
    rst = 1'b0;
    edge_sample();
    checks++;
    if (reg_if.out !== 2'b10) begin
      errors++;
      $display("FAIL midrst_resume: out=%b expected=10", reg_if.out);
    end
  endtask

  task automatic test_comb();
    logic [2:0] vec [8];
    logic [1:0] exp [8];
    vec = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011, 3'b101, 3'b110, 3'b111};
    exp = '{2'b00,  2'b01,  2'b01,  2'b01,  2'b10,  2'b10,  2'b10,  2'b11};
    for (int r = 0; r < 2; r++) begin
      rst_comb = (r == 1);
      for (int i = 0; i < 8; i++) begin
        comb_if.in = vec[i];
        #1;
        checks++;
        if (comb_if.out !== exp[i]) begin
          errors++;
          $display("FAIL comb in=%b rst=%0d: out=%b expected=%b", vec[i], r, comb_if.out, exp[i]);
        end
      end
    end
    rst_comb = 1'b0;
  endtask

  task automatic test_two_lanes();
    logic [5:0] vec [4];
    logic [3:0] exp [4];
    vec = '{6'b111_001, 6'b001_111, 6'b000_011, 6'b101_110};
    exp = '{4'b11_01,   4'b01_11,   4'b00_10,   4'b10_10};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      two_if.in = vec[i];
      edge_sample();
      checks++;
      if (two_if.out !== exp[i]) begin
        errors++;
        $display("FAIL two_lanes in=%b: out=%b expected=%b", vec[i], two_if.out, exp[i]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reg_if.in  = 3'b000;
    comb_if.in = 3'b000;
    two_if.in  = 6'b000_000;
    test_reset();
    test_sweep();
    test_latency();
    test_midstream_reset();
    test_comb();
    test_two_lanes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
